eep_code_loader: RTL and testbench

EEP_CODE_LOADER -- requirements
Module: eep_code_loader

---
 rtl/eep_code_loader.sv | 144 ++++++++++++++
 tb/tb_eep_code_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/eep_code_loader.sv
// Boot-time code loader: turns a length-prefixed byte stream into code-memory word writes, then enables the core.
// Optional EEP_LOADER_CHECKSUM_EN: a trailing XOR checksum byte must match before the core is released.
module eep_code_loader #(
  parameter int REG_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 reload,
  output logic                 mem_wen,
  output logic [REG_WIDTH-1:0] mem_addr,
  output logic [REG_WIDTH-1:0] mem_din,
  output logic                 cpen,
  output logic                 err
);

  localparam int BYTES = REG_WIDTH / 8;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA_LO,
    DATA_HI,
    CSUM,
    RUN,
    ERROR
  } state_t;

`ifdef EEP_LOADER_CHECKSUM_EN
  localparam state_t LOAD_DONE = CSUM;
`else
  localparam state_t LOAD_DONE = RUN;
`endif

  state_t               state;
  state_t               state_next;
  logic [15:0]          count;
  logic [7:0]           byte_idx;
  logic [REG_WIDTH-9:0] word_buf;
  logic [REG_WIDTH-1:0] word_idx;
  logic                 accept;
  logic                 last_word;
`ifdef EEP_LOADER_CHECKSUM_EN
  logic [7:0]           csum;
`endif

  assign accept    = in_valid && in_ready;
  assign last_word = (word_idx[15:0] + 16'd1) == count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LEN_LO;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (reload) begin
      state_next = LEN_LO;
    end else begin
      case (state)
        LEN_LO:  if (accept) state_next = LEN_HI;
        LEN_HI:  if (accept) state_next = ({in_data, count[7:0]} == 16'd0) ? LOAD_DONE : DATA_LO;
        DATA_LO: if (accept && byte_idx == 8'(BYTES - 2)) state_next = DATA_HI;
        DATA_HI: if (accept) state_next = last_word ? LOAD_DONE : DATA_LO;
`ifdef EEP_LOADER_CHECKSUM_EN
        CSUM:    if (accept) state_next = (in_data == csum) ? RUN : ERROR;
`else
        CSUM:    state_next = RUN;
`endif
        RUN:     state_next = RUN;
        ERROR:   state_next = ERROR;
        default: state_next = LEN_LO;
      endcase
    end
  end

  // cpen waits out the final write strobe so the core never starts while memory is still being written.
  always_comb begin
    in_ready = 1'b0;
    cpen     = 1'b0;
    err      = 1'b0;
    case (state)
      LEN_LO, LEN_HI, DATA_LO, DATA_HI, CSUM: in_ready = !reload && !rst;
      RUN:     cpen = !mem_wen;
      ERROR:   err  = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      byte_idx <= '0;
      word_buf <= '0;
      word_idx <= '0;
      mem_wen  <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
`ifdef EEP_LOADER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else if (reload) begin
      count    <= '0;
      byte_idx <= '0;
      word_idx <= '0;
      mem_wen  <= 1'b0;
      mem_addr <= '0;
`ifdef EEP_LOADER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      mem_wen <= 1'b0;
      if (accept) begin
        case (state)
          LEN_LO: count[7:0]  <= in_data;
          LEN_HI: count[15:8] <= in_data;
          DATA_LO: begin
            for (int i = 0; i < BYTES - 1; i++) begin
              if (byte_idx == 8'(i)) word_buf[i*8 +: 8] <= in_data;
            end
            byte_idx <= byte_idx + 8'd1;
`ifdef EEP_LOADER_CHECKSUM_EN
            csum     <= csum ^ in_data;
`endif
          end
          DATA_HI: begin
            mem_wen  <= 1'b1;
            mem_din  <= {in_data, word_buf};
            mem_addr <= word_idx;
            word_idx <= word_idx + REG_WIDTH'(1);
            byte_idx <= '0;
`ifdef EEP_LOADER_CHECKSUM_EN
            csum     <= csum ^ in_data;
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eep_code_loader.sv
// Directed bench for eep_code_loader: expected writes are queued as bytes are driven and popped on each mem_wen.
// Follows EEP_LOADER_CHECKSUM_EN the same way the design does.
module tb_eep_code_loader;

  localparam int REG_WIDTH = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [7:0]           in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic                 reload;
  logic                 mem_wen;
  logic [REG_WIDTH-1:0] mem_addr;
  logic [REG_WIDTH-1:0] mem_din;
  logic                 cpen;
  logic                 err;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  eep_code_loader #(.REG_WIDTH(REG_WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .reload   (reload),
    .mem_wen  (mem_wen),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .cpen     (cpen),
    .err      (err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic expectWrite(input logic [31:0] addr, input logic [31:0] data);
    exp_addr_q.push_back(addr);
    exp_data_q.push_back(data);
  endtask

  // Each write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (mem_wen === 1'b1) begin
      checkOutput("write_pending", 32'(exp_addr_q.size() != 0), 32'd1);
      if (exp_addr_q.size() != 0) begin
        checkOutput("wr_addr", 32'(mem_addr), exp_addr_q.pop_front());
        checkOutput("wr_data", 32'(mem_din), exp_data_q.pop_front());
      end
    end
  end

  // Offers one byte after an idle gap; returns just after the edge on which it transferred.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    logic accepted;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    accepted = 1'b0;
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(negedge clk);
      accepted = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checkOutput("byte_accepted", 32'(accepted), 32'd1);
  endtask

  task automatic doReload();
    reload = 1'b1;
    @(negedge clk);
    checkOutput("ready_during_reload", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    reload = 1'b0;
    @(negedge clk);
    checkOutput("reload_cpen", 32'(cpen), 32'd0);
    checkOutput("reload_err", 32'(err), 32'd0);
    checkOutput("reload_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic sendStream31(input int maxgap);
    logic [7:0] s [6];
    s = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
    expectWrite(32'h0, 32'h1234);
    expectWrite(32'h1, 32'h5678);
    for (int i = 0; i < 6; i++) applyStimulus(s[i], int'($urandom_range(maxgap, 0)));
`ifdef EEP_LOADER_CHECKSUM_EN
    applyStimulus(8'h08, int'($urandom_range(maxgap, 0)));
`else
    @(negedge clk);
    checkOutput("last_write_wen", 32'(mem_wen), 32'd1);
    checkOutput("cpen_during_last_write", 32'(cpen), 32'd0);
`endif
    @(negedge clk);
    checkOutput("cpen_after_load", 32'(cpen), 32'd1);
    checkOutput("err_after_load", 32'(err), 32'd0);
    checkOutput("ready_in_run", 32'(in_ready), 32'd0);
    checkOutput("writes_drained", 32'(exp_addr_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    reload   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_mem_wen", 32'(mem_wen), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_mem_din", 32'(mem_din), 32'd0);
    checkOutput("rst_cpen", 32'(cpen), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_rst", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    $display("[TB] two-word stream, no gaps");
    sendStream31(0);

    $display("[TB] empty stream");
    doReload();
    applyStimulus(8'h00, 0);
    applyStimulus(8'h00, 0);
`ifdef EEP_LOADER_CHECKSUM_EN
    applyStimulus(8'h00, 0);
`endif
    @(negedge clk);
    checkOutput("empty_cpen", 32'(cpen), 32'd1);
    checkOutput("empty_err", 32'(err), 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] reload in the middle of word 1");
    doReload();
    expectWrite(32'h0, 32'h1234);
    applyStimulus(8'h02, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h34, 0);
    applyStimulus(8'h12, 0);
    in_valid = 1'b1;
    in_data  = 8'h78;
    reload   = 1'b1;
    @(negedge clk);
    checkOutput("ready_with_reload", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    reload   = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("restart_ready", 32'(in_ready), 32'd1);
    checkOutput("restart_wen", 32'(mem_wen), 32'd0);
    checkOutput("restart_cpen", 32'(cpen), 32'd0);
    @(posedge clk);
    #1;
    sendStream31(0);

    $display("[TB] two-word stream with random gaps");
    doReload();
    sendStream31(5);

`ifdef EEP_LOADER_CHECKSUM_EN
    $display("[TB] bad checksum");
    doReload();
    expectWrite(32'h0, 32'h55AA);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'hAA, 0);
    applyStimulus(8'h55, 0);
    applyStimulus(8'h00, 0);
    @(negedge clk);
    checkOutput("csum_err", 32'(err), 32'd1);
    checkOutput("csum_cpen", 32'(cpen), 32'd0);
    checkOutput("csum_ready", 32'(in_ready), 32'd0);
    checkOutput("csum_writes_drained", 32'(exp_addr_q.size()), 32'd0);
    @(posedge clk);
    #1;
`endif

    $display("[TB] reset during DATA_HI");
    doReload();
    expectWrite(32'h0, 32'h1234);
    applyStimulus(8'h02, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h34, 0);
    applyStimulus(8'h12, 0);
    applyStimulus(8'h78, 0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_ready", 32'(in_ready), 32'd0);
    checkOutput("async_rst_wen", 32'(mem_wen), 32'd0);
    checkOutput("async_rst_addr", 32'(mem_addr), 32'd0);
    checkOutput("async_rst_din", 32'(mem_din), 32'd0);
    checkOutput("async_rst_cpen", 32'(cpen), 32'd0);
    checkOutput("async_rst_err", 32'(err), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h56;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    rst      = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("no_write_after_rst", 32'(mem_wen), 32'd0);
    end
    checkOutput("rst_writes_drained", 32'(exp_addr_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
